// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo_if
//  Description : Host read port of the UART receive FIFO. Valid/ready
//                handshake carrying the head frame (8-bit data plus 3-bit
//                receiver error flags).
//                  rd_valid : FIFO -> host, head entry is presented
//                  rd_ready : host -> FIFO, host accepts the head entry
//                  rd_data  : FIFO -> host, head entry data
//                  rd_error : FIFO -> host, head entry error flags
//                Modport master = FIFO side, modport slave = host side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic [2:0] rd_error;

    modport master (
        output rd_valid,
        output rd_data,
        output rd_error,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        input  rd_error,
        output rd_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Receive buffer behind the UART receiver. Captures one frame
//                ({rx_error, rx_data}) on each rising edge of done_flag into
//                a circular FIFO and presents it show-ahead on a valid/ready
//                read port. Keeps a sticky overflow flag and a saturating
//                count of errored frames.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                done_flag     - receiver frame-complete level
//                rx_data       - receiver data byte
//                rx_error      - receiver error flags
//                clr_ovf       - clear overflow (a coincident drop wins)
//                clr_stat      - clear err_count (wins over increment)
//                rd_if         - host read port (master side)
//                level         - stored entry count, 0..DEPTH
//                full, empty   - decoded from level
//                overflow      - sticky, a frame was dropped
//                err_count     - saturating count of frames with errors
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          done_flag,
    input  wire logic [7:0]    rx_data,
    input  wire logic [2:0]    rx_error,
    input  wire logic          clr_ovf,
    input  wire logic          clr_stat,
    uart_rx_fifo_if.master     rd_if,
    output logic      [AW:0]   level,
    output logic               full,
    output logic               empty,
    output logic               overflow,
    output logic      [7:0]    err_count
);

    localparam logic [AW:0] c_full_level = (AW+1)'(DEPTH);
    localparam logic [7:0]  c_err_max    = 8'hFF;

    logic              r_done_q;
    logic [AW-1:0]     r_wp;
    logic [AW-1:0]     r_rp;
    logic [AW:0]       r_level;
    logic              r_overflow;
    logic [7:0]        r_err_count;
    logic [10:0]       r_mem [DEPTH];

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_nonempty;
    logic              w_accept;
    logic              w_drop;
    logic [10:0]       w_head;

    // One push per high period of done_flag. r_done_q resets high so a level
    // already present when reset releases is not taken as a new frame.
    assign w_push     = done_flag & ~r_done_q;
    assign w_full     = (r_level == c_full_level);
    assign w_nonempty = (r_level != '0);
    assign w_pop      = w_nonempty & rd_if.rd_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // only dropped when nothing is read out.
    assign w_accept   = w_push & (~w_full | w_pop);
    assign w_drop     = w_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_q    <= 1'b1;
            r_wp        <= '0;
            r_rp        <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_done_q <= done_flag;

            if (w_accept) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end

            if (w_accept && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_accept) begin
                r_level <= r_level - 1'b1;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end

            // Dropped frames still count; clear beats a coincident increment.
            if (clr_stat) begin
                r_err_count <= '0;
            end else if (w_push && (rx_error != 3'b000) && (r_err_count != c_err_max)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    // Storage is not reset; the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wp] <= {rx_error, rx_data};
        end
    end

    assign w_head         = r_mem[r_rp];
    assign rd_if.rd_valid = w_nonempty;
    assign rd_if.rd_data  = w_head[7:0];
    assign rd_if.rd_error = w_head[10:8];

    assign level     = r_level;
    assign full      = w_full;
    assign empty     = ~w_nonempty;
    assign overflow  = r_overflow;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo. Frames expected to be
//                stored are queued when issued; a monitor compares every
//                frame the DUT hands over against the queue head. Status
//                outputs are checked directly against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          rst;
    logic          done_flag;
    logic [7:0]    rx_data;
    logic [2:0]    rx_error;
    logic          clr_ovf;
    logic          clr_stat;
    logic [AW:0]   level;
    logic          full;
    logic          empty;
    logic          overflow;
    logic [7:0]    err_count;

    uart_rx_fifo_if rd_if ();

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .done_flag (done_flag),
        .rx_data   (rx_data),
        .rx_error  (rx_error),
        .clr_ovf   (clr_ovf),
        .clr_stat  (clr_stat),
        .rd_if     (rd_if),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: a transfer completes on the next rising edge whenever valid
    // and ready are both high at the falling edge.
    always @(negedge clk) begin
        if (!rst && rd_if.rd_valid && rd_if.rd_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL read_unexpected actual %0h required none",
                         {rd_if.rd_error, rd_if.rd_data});
            end else begin
                if ({rd_if.rd_error, rd_if.rd_data} != exp_q[0]) begin
                    errors++;
                    $display("FAIL read_frame actual %0h required %0h",
                             {rd_if.rd_error, rd_if.rd_data}, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame: done_flag high for one cycle then low for one cycle.
    task automatic push_frame(input logic [7:0] d, input logic [2:0] e, input bit stored);
        done_flag = 1'b1;
        rx_data   = d;
        rx_error  = e;
        if (stored) exp_q.push_back({e, d});
        tick();
        done_flag = 1'b0;
        tick();
    endtask

    task automatic drain();
        int n;
        rd_if.rd_ready = 1'b1;
        n = 0;
        while (!empty && n < 64) begin
            tick();
            n++;
        end
        rd_if.rd_ready = 1'b0;
        chk("drain_empty", int'(empty), 1);
        chk("drain_queue_left", exp_q.size(), 0);
    endtask

    initial begin
        rst            = 1'b1;
        done_flag      = 1'b0;
        rx_data        = 8'h00;
        rx_error       = 3'b000;
        clr_ovf        = 1'b0;
        clr_stat       = 1'b0;
        rd_if.rd_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_rd_valid", int'(rd_if.rd_valid), 0);
        chk("rst_empty",    int'(empty), 1);
        chk("rst_full",     int'(full), 0);
        chk("rst_level",    int'(level), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_err_count", int'(err_count), 0);

        // Single frame, one cycle of latency
        done_flag = 1'b1;
        rx_data   = 8'hA5;
        rx_error  = 3'b000;
        exp_q.push_back({3'b000, 8'hA5});
        tick();
        chk("single_valid", int'(rd_if.rd_valid), 1);
        chk("single_data",  int'(rd_if.rd_data), 'hA5);
        chk("single_level", int'(level), 1);
        done_flag      = 1'b0;
        rd_if.rd_ready = 1'b1;
        tick();
        rd_if.rd_ready = 1'b0;
        chk("single_empty", int'(empty), 1);
        chk("single_level0", int'(level), 0);

        // Long done_flag level gives exactly one entry
        done_flag = 1'b1;
        rx_data   = 8'h3C;
        exp_q.push_back({3'b000, 8'h3C});
        repeat (20) tick();
        done_flag = 1'b0;
        tick();
        chk("long_level", int'(level), 1);
        drain();

        // done_flag high through reset release gives no entry
        rst       = 1'b1;
        done_flag = 1'b1;
        rx_data   = 8'hEE;
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("rstlevel_level", int'(level), 0);
        chk("rstlevel_valid", int'(rd_if.rd_valid), 0);
        done_flag = 1'b0;
        tick();

        // Fill, overflow, drain in order
        for (int i = 0; i < 16; i++) push_frame(8'(i), 3'b000, 1'b1);
        chk("fill_full",  int'(full), 1);
        chk("fill_level", int'(level), 16);
        chk("fill_ovf0",  int'(overflow), 0);
        push_frame(8'h10, 3'b000, 1'b0);
        chk("drop_overflow", int'(overflow), 1);
        chk("drop_level",    int'(level), 16);
        drain();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_cleared", int'(overflow), 0);

        // Full with simultaneous push and pop; 55 lands after wrap-around
        for (int i = 0; i < 16; i++) push_frame(8'(8'h20 + i), 3'b000, 1'b1);
        done_flag      = 1'b1;
        rx_data        = 8'h55;
        rx_error       = 3'b000;
        rd_if.rd_ready = 1'b1;
        exp_q.push_back({3'b000, 8'h55});
        tick();
        done_flag      = 1'b0;
        rd_if.rd_ready = 1'b0;
        tick();
        chk("pp_level",    int'(level), 16);
        chk("pp_overflow", int'(overflow), 0);
        chk("pp_full",     int'(full), 1);

        // Clear precedence: drop and clr_ovf together leave overflow set
        done_flag = 1'b1;
        rx_data   = 8'h77;
        clr_ovf   = 1'b1;
        tick();
        done_flag = 1'b0;
        clr_ovf   = 1'b0;
        tick();
        chk("clrovf_set_wins", int'(overflow), 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clrovf_alone", int'(overflow), 0);
        drain();

        // Error tagging
        push_frame(8'h01, 3'b010, 1'b1);
        push_frame(8'h02, 3'b010, 1'b1);
        push_frame(8'h03, 3'b010, 1'b1);
        push_frame(8'h04, 3'b000, 1'b1);
        chk("err_count3", int'(err_count), 3);
        drain();

        // clr_stat wins over an errored push
        done_flag = 1'b1;
        rx_data   = 8'h99;
        rx_error  = 3'b111;
        clr_stat  = 1'b1;
        exp_q.push_back({3'b111, 8'h99});
        tick();
        done_flag = 1'b0;
        clr_stat  = 1'b0;
        chk("clrstat_wins", int'(err_count), 0);
        tick();
        drain();

        // Saturation: 300 errored frames while reading continuously
        rd_if.rd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            push_frame(8'(i), 3'((i % 7) + 1), 1'b1);
            if (i == 254) chk("err_count255", int'(err_count), 255);
        end
        chk("err_sat", int'(err_count), 255);
        chk("err_sat_ovf", int'(overflow), 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual running required finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
